// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit core: opcodes, instruction width and the
// program-fetch FSM state encoding.
package cpu_pkg;

  localparam int INSTR_W = 8;

  localparam logic [1:0] OP_IN  = 2'b00;
  localparam logic [1:0] OP_ADD = 2'b01;
  localparam logic [1:0] OP_MOV = 2'b10;
  localparam logic [1:0] OP_OUT = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } fetch_state_e;

  // Instruction layout is {op[1:0], f1[2:0], f0[2:0]}.
  function automatic logic [1:0] instr_op(input logic [INSTR_W-1:0] instr);
    return instr[INSTR_W-1 -: 2];
  endfunction

endpackage

// File: rtl/prog_fetch_if.sv
// Host-side load/control and core-side instruction stream of prog_fetch.
// The host/bench drives through the master modport, the fetch unit is the slave.
interface prog_fetch_if import cpu_pkg::*; #(parameter int AW = 5);

  logic               load_en;
  logic [AW-1:0]      load_addr;
  logic [INSTR_W-1:0] load_data;
  logic [AW:0]        prog_len;
  logic               start;
  logic               abort;
  logic               stall;
  logic [INSTR_W-1:0] instr_out;
  logic               instr_valid;
  logic [AW-1:0]      pc;
  logic               busy;
  logic               done;

  modport master (
    output load_en, load_addr, load_data, prog_len, start, abort, stall,
    input  instr_out, instr_valid, pc, busy, done
  );

  modport slave (
    input  load_en, load_addr, load_data, prog_len, start, abort, stall,
    output instr_out, instr_valid, pc, busy, done
  );

endinterface

// File: rtl/prog_mem.sv
// Program store: DEPTH x INSTR_W words, synchronous write, asynchronous read.
// Contents are deliberately not reset so a program survives a core reset.
module prog_mem import cpu_pkg::*; #(
  parameter int DEPTH = 32,
  parameter int AW    = 5
) (
  input  logic               clk,
  input  logic               we,
  input  logic [AW-1:0]      waddr,
  input  logic [INSTR_W-1:0] wdata,
  input  logic [AW-1:0]      raddr,
  output logic [INSTR_W-1:0] rdata
);

  logic [INSTR_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/prog_fetch.sv
// Program sequencer: replays the stored program to the execute core, one word
// per unstalled cycle. Define FETCH_LOOP_EN to replay the program endlessly.
module prog_fetch import cpu_pkg::*; #(
  parameter int DEPTH = 32,
  parameter int AW    = 5
) (
  input  logic clk,
  input  logic rst,
  prog_fetch_if.slave bus
);

  localparam logic [AW:0] LEN_MAX = (AW+1)'(DEPTH);
  localparam logic [AW:0] LEN_ONE = (AW+1)'(1);
`ifndef FETCH_LOOP_EN
  localparam logic [AW-1:0] PC_MAX = AW'(DEPTH - 1);
`endif

  fetch_state_e       state_q, state_d;
  logic [AW-1:0]      pc_q, pc_d;
  logic [AW:0]        len_q, len_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic               valid_q, valid_d;
  logic               last_q, last_d;
  logic               done_q, done_d;

  logic [INSTR_W-1:0] mem_rdata;
  logic               mem_we;
  logic               fetch_last;
  logic               retire_last;
  logic [AW:0]        len_clamped;

  assign mem_we      = bus.load_en && (state_q == ST_IDLE);
  assign fetch_last  = ({1'b0, pc_q} == (len_q - LEN_ONE));
  // last_q marks that the word on instr_out is the final one of the program.
  assign retire_last = valid_q && last_q && !bus.stall;
  assign len_clamped = (bus.prog_len > LEN_MAX) ? LEN_MAX : bus.prog_len;

  prog_mem #(.DEPTH(DEPTH), .AW(AW)) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (bus.load_addr),
    .wdata (bus.load_data),
    .raddr (pc_q),
    .rdata (mem_rdata)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      pc_q    <= '0;
      len_q   <= '0;
      instr_q <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      len_q   <= len_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    len_d   = len_q;
    instr_d = instr_q;
    valid_d = valid_q;
    last_d  = last_q;
    done_d  = 1'b0;

    // Abort wins over stall and start whenever a run is in progress.
    if (bus.abort && (state_q != ST_IDLE)) begin
      state_d = ST_IDLE;
      valid_d = 1'b0;
      instr_d = '0;
      last_d  = 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (bus.start) begin
            if (bus.prog_len == '0) begin
              done_d = 1'b1;
            end else begin
              state_d = ST_RUN;
              pc_d    = '0;
              len_d   = len_clamped;
            end
          end
        end
        ST_RUN: begin
          if (!bus.stall) begin
            instr_d = mem_rdata;
            valid_d = 1'b1;
            last_d  = fetch_last;
            done_d  = retire_last;
`ifdef FETCH_LOOP_EN
            pc_d    = fetch_last ? '0 : pc_q + 1'b1;
`else
            pc_d    = (pc_q == PC_MAX) ? pc_q : pc_q + 1'b1;
            if (fetch_last) state_d = ST_DRAIN;
`endif
          end
        end
        ST_DRAIN: begin
          if (!bus.stall) begin
            state_d = ST_IDLE;
            valid_d = 1'b0;
            instr_d = '0;
            last_d  = 1'b0;
            done_d  = retire_last;
          end
        end
        default: begin
          state_d = ST_IDLE;
          valid_d = 1'b0;
          instr_d = '0;
          last_d  = 1'b0;
        end
      endcase
    end
  end

  assign bus.instr_out   = instr_q;
  assign bus.instr_valid = valid_q;
  assign bus.pc          = pc_q;
  assign bus.busy        = (state_q != ST_IDLE);
  assign bus.done        = done_q;

endmodule

// File: tb/tb_prog_fetch.sv
// Randomised self-checking bench for prog_fetch; the reference model is a
// queue of expected words that advances one entry per unstalled cycle.
module tb_prog_fetch;

  localparam int DEPTH = 32;
  localparam int AW    = 5;

  logic clk;
  logic rst;

  int checks_total;
  int checks_passed;

  logic [7:0] model_mem [DEPTH];

  prog_fetch_if #(.AW(AW)) bus ();

  prog_fetch #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks_total++;
    if (actual !== expected)
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, actual, expected, $time);
    else
      checks_passed++;
  endtask

  task automatic applyStimulus(input logic le, input logic [AW-1:0] la, input logic [7:0] ld,
                               input logic st, input logic ab, input logic sl);
    bus.load_en   = le;
    bus.load_addr = la;
    bus.load_data = ld;
    bus.start     = st;
    bus.abort     = ab;
    bus.stall     = sl;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_word(input int addr, input logic [7:0] data);
    applyStimulus(1'b1, AW'(addr), data, 1'b0, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    model_mem[addr] = data;
  endtask

  // One run: start, then follow the stream with the given stall policy and
  // optional abort, bad load during the run, or load in the start cycle.
  task automatic run_and_check(input int len_req, input int stall_pct, input int stall_at,
                               input int stall_len, input int abort_at, input bit bad_load,
                               input bit load_with_start);
    int eff_len, idx, cycles, stall_left;
    bit shown, running, exp_done, s, a;
    logic [7:0] exp_q[$];
    logic [7:0] new_word;

    eff_len = (len_req > DEPTH) ? DEPTH : len_req;
    if (load_with_start) begin
      new_word = 8'($urandom);
      applyStimulus(1'b1, '0, new_word, 1'b0, 1'b0, 1'b0);
      model_mem[0] = new_word;
    end
    exp_q = {};
    for (int i = 0; i < eff_len; i++) exp_q.push_back(model_mem[i]);

    bus.prog_len = (AW+1)'(len_req);
    bus.start    = 1'b1;
    tick();
    bus.start   = 1'b0;
    bus.load_en = 1'b0;

    if (eff_len == 0) begin
      checkOutput("zero_len_done", bus.done, 1);
      checkOutput("zero_len_busy", bus.busy, 0);
      checkOutput("zero_len_valid", bus.instr_valid, 0);
      tick();
      checkOutput("zero_len_done_pulse", bus.done, 0);
      checkOutput("zero_len_busy_after", bus.busy, 0);
      return;
    end

    checkOutput("start_busy", bus.busy, 1);
    checkOutput("start_no_valid", bus.instr_valid, 0);

    shown = 0; idx = 0; running = 1; cycles = 0; a = 0;
    stall_left = stall_len;
    while (running && cycles < 4*DEPTH + 200) begin
      a = (abort_at >= 0) && shown && (idx == abort_at);
      if (shown && idx == stall_at && stall_left > 0) begin
        s = 1;
        stall_left--;
      end else begin
        s = ($urandom_range(99) < stall_pct);
      end
      bus.stall = s;
      bus.abort = a;
      if (bad_load && cycles == 0) begin
        bus.load_en   = 1'b1;
        bus.load_addr = AW'(1);
        bus.load_data = 8'hFF;
      end
      tick();
      bus.abort   = 1'b0;
      bus.load_en = 1'b0;
      cycles++;

      exp_done = 0;
      if (a) begin
        shown = 0;
        running = 0;
      end else if (!s) begin
        if (shown && idx == eff_len - 1) begin
          shown = 0;
          running = 0;
          exp_done = 1;
        end else begin
          idx = shown ? idx + 1 : 0;
          shown = 1;
        end
      end

      checkOutput("valid", bus.instr_valid, shown);
      if (shown) begin
        checkOutput("instr", bus.instr_out, exp_q[idx]);
        if (idx + 1 < DEPTH) checkOutput("pc", bus.pc, idx + 1);
      end
      checkOutput("done", bus.done, exp_done);
      checkOutput("busy", bus.busy, running);
      if (exp_done) checkOutput("done_instr_zero", bus.instr_out, 0);
    end
    checkOutput("run_timeout", running, 0);

    bus.stall = 1'b0;
    tick();
    if (a) checkOutput("abort_no_done", bus.done, 0);
    else   checkOutput("done_single_cycle", bus.done, 0);
    checkOutput("idle_after_run", bus.busy, 0);
  endtask

  initial begin
    int len, eff, ab;
    checks_total  = 0;
    checks_passed = 0;
    rst = 1'b0;
    bus.prog_len = '0;
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);

    #2;
    checkOutput("reset_instr", bus.instr_out, 0);
    checkOutput("reset_valid", bus.instr_valid, 0);
    checkOutput("reset_pc", bus.pc, 0);
    checkOutput("reset_busy", bus.busy, 0);
    checkOutput("reset_done", bus.done, 0);
    #10 rst = 1'b1;

    for (int i = 0; i < DEPTH; i++) load_word(i, 8'($urandom));
    load_word(0, 8'h00);
    load_word(1, 8'h08);
    load_word(2, 8'h41);
    load_word(3, 8'hC8);

`ifdef FETCH_LOOP_EN
    bus.prog_len = (AW+1)'(2);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int k = 0; k < 6; k++) begin
      tick();
      checkOutput("loop_valid", bus.instr_valid, 1);
      checkOutput("loop_instr", bus.instr_out, model_mem[k % 2]);
      checkOutput("loop_done", bus.done, (k >= 2 && k % 2 == 0) ? 1 : 0);
    end
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    checkOutput("loop_abort_valid", bus.instr_valid, 0);
    checkOutput("loop_abort_busy", bus.busy, 0);
    checkOutput("loop_abort_done", bus.done, 0);
`else
    run_and_check(4, 0, -1, 0, -1, 0, 0);
    run_and_check(4, 0, 1, 3, -1, 0, 0);
    run_and_check(0, 0, -1, 0, -1, 0, 0);
    run_and_check(4, 0, -1, 0, -1, 1, 0);
    run_and_check(4, 0, -1, 0, -1, 0, 0);
    run_and_check(4, 0, -1, 0, 1, 0, 0);

    bus.prog_len = (AW+1)'(4);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int k = 0; k < 3; k++) tick();
    checkOutput("pre_reset_pc", bus.pc, 3);
    #2 rst = 1'b0;
    #1;
    checkOutput("midrun_reset_instr", bus.instr_out, 0);
    checkOutput("midrun_reset_valid", bus.instr_valid, 0);
    checkOutput("midrun_reset_pc", bus.pc, 0);
    checkOutput("midrun_reset_busy", bus.busy, 0);
    checkOutput("midrun_reset_done", bus.done, 0);
    #2 rst = 1'b1;
    run_and_check(4, 0, -1, 0, -1, 0, 0);

    run_and_check(4, 0, -1, 0, -1, 0, 1);
    run_and_check(DEPTH + 5, 0, -1, 0, -1, 0, 0);

    for (int r = 0; r < 8; r++) begin
      for (int w = 0; w < 4; w++) load_word($urandom_range(DEPTH - 1), 8'($urandom));
      len = $urandom_range(1, DEPTH + 4);
      eff = (len > DEPTH) ? DEPTH : len;
      ab  = ($urandom_range(3) == 0) ? $urandom_range(eff - 1) : -1;
      run_and_check(len, 30, -1, 0, ab, 0, 0);
    end
`endif

    $display("[TB] %0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
